// File: rtl/vector_checker.sv
// Vector player/checker: streams {valid, in, exp} words from a synchronous ROM into a
// clocked DUT, then checks the DUT output one DUT clock after each stimulus is applied.
module vector_checker #(
    parameter int W_IN  = 2,
    parameter int W_OUT = 1,
    parameter int AW    = 8,
    parameter int CW    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic [AW-1:0]           vec_addr,
    input  logic [W_IN+W_OUT:0]     vec_data,
    output logic [W_IN-1:0]         dut_in,
    input  logic [W_OUT-1:0]        dut_out,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [CW-1:0]           err_count,
    output logic [AW-1:0]           first_err_addr
);

    typedef enum logic [2:0] {IDLE, FETCH, APPLY, SETTLE, CHECK, DONE} state_t;

    state_t             state, nxt;
    logic [W_OUT-1:0]   exp_reg;
    logic               err_seen;

    logic               word_vld;
    logic [W_IN-1:0]    word_in;
    logic [W_OUT-1:0]   word_exp;
    logic               mism;
    logic               last_addr;

    assign word_vld  = vec_data[W_IN+W_OUT];
    assign word_in   = vec_data[W_OUT +: W_IN];
    assign word_exp  = vec_data[W_OUT-1:0];
    assign mism      = (dut_out != exp_reg);
    assign last_addr = &vec_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: if (start) nxt = FETCH;
            FETCH:      nxt = APPLY;
            APPLY:      nxt = word_vld ? SETTLE : DONE;
            SETTLE:     nxt = CHECK;
            CHECK:      nxt = last_addr ? DONE : FETCH;
            default:    nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_addr       <= '0;
            dut_in         <= '0;
            exp_reg        <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            err_seen       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec_addr       <= '0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        err_seen       <= 1'b0;
                    end
                end
                APPLY: begin
                    // an invalid word is the end-of-table sentinel; stimulus is left as-is
                    if (word_vld) begin
                        dut_in  <= word_in;
                        exp_reg <= word_exp;
                    end
                end
                CHECK: begin
                    if (mism) begin
                        if (err_count != '1) err_count <= err_count + CW'(1);
                        if (!err_seen) begin
                            first_err_addr <= vec_addr;
                            err_seen       <= 1'b1;
                        end
                    end
                    if (!last_addr) vec_addr <= vec_addr + AW'(1);
                end
                default: ;
            endcase
        end
    end

    // status is decoded from state so it follows reset and restarts without extra flops
    assign busy = (state == FETCH) || (state == APPLY) || (state == SETTLE) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_vector_checker.sv
// Bench for vector_checker: two checkers (CW=8 and CW=2) each drive a Bit-chip model
// from a shared vector table; results are checked against a table-walking reference.
module tb_vector_checker;

    localparam int W_IN = 2, W_OUT = 1, AW = 8;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rom [256];

    // instance 0: CW=8
    logic [AW-1:0] vec_addr0, ferr0;
    logic [3:0]    rd0;
    logic [1:0]    dut_in0;
    logic          bit0 = 1'b0;
    logic          busy0, done0, pass0;
    logic [7:0]    err0;
    // instance 1: CW=2
    logic [AW-1:0] vec_addr1, ferr1;
    logic [3:0]    rd1;
    logic [1:0]    dut_in1;
    logic          bit1 = 1'b0;
    logic          busy1, done1, pass1;
    logic [1:0]    err1;

    always @(posedge clk) begin
        rd0  <= rom[vec_addr0];
        rd1  <= rom[vec_addr1];
        bit0 <= dut_in0[0] ? dut_in0[1] : bit0;
        bit1 <= dut_in1[0] ? dut_in1[1] : bit1;
    end

    vector_checker #(.W_IN(W_IN), .W_OUT(W_OUT), .AW(AW), .CW(8)) u0 (
        .clk(clk), .reset(reset), .start(start), .vec_addr(vec_addr0), .vec_data(rd0),
        .dut_in(dut_in0), .dut_out(bit0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_err_addr(ferr0));

    vector_checker #(.W_IN(W_IN), .W_OUT(W_OUT), .AW(AW), .CW(2)) u1 (
        .clk(clk), .reset(reset), .start(start), .vec_addr(vec_addr1), .vec_data(rd1),
        .dut_in(dut_in1), .dut_out(bit1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_addr(ferr1));

    int nvec = 0, nerr = 0;

    // vector table (in, load, expected) and reference state carried between runs
    int   n;
    logic tin [16], tload [16], texp [16];
    logic mbit = 1'b0;
    logic [1:0] mdin = 2'b00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic build_rom();
        for (int a = 0; a < 256; a++) rom[a] = 4'h0;
        for (int i = 0; i < n; i++) rom[i] = {1'b1, tin[i], tload[i], texp[i]};
    endtask

    // walk the first 'upto' vectors as a Bit chip would see them
    task automatic model(input int upto, inout logic b, output int cnt, output int ferr);
        cnt = 0; ferr = 0;
        for (int i = 0; i < upto; i++) begin
            if (tload[i]) b = tin[i];
            if (b != texp[i]) begin
                if (cnt == 0) ferr = i;
                cnt++;
            end
        end
    endtask

    task automatic set_vec(input int i, input logic in, input logic ld, input logic ex);
        tin[i] = in; tload[i] = ld; texp[i] = ex;
    endtask

    // glitch: cycle at which a stray start is presented; abort: cycle at which reset hits
    task automatic run(input int glitch, input int abort);
        int cyc, cnt, ferr;
        logic b;
        b = mbit;
        build_rom();
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0; cyc = 0;
        chk("busy_after_start", busy0, 1);
        chk("done_cleared", done0, 0);
        while (!done0 && cyc < 2000) begin
            @(negedge clk); cyc++;
            start = (cyc == glitch);
            if (cyc == abort) begin
                reset = 1'b1; #1;
                chk("abort_vec_addr", vec_addr0, 0);
                chk("abort_dut_in", dut_in0, 0);
                chk("abort_busy", busy0, 0);
                chk("abort_done", done0, 0);
                chk("abort_err", err0, 0);
                chk("abort_ferr", ferr0, 0);
                chk("abort_busy1", busy1, 0);
                reset = 1'b0;
                model(2, b, cnt, ferr);
                mbit = b; mdin = 2'b00;
                return;
            end
        end
        start = 1'b0;
        model(n, b, cnt, ferr);
        chk("done_cycle", cyc, 4 * n + 2);
        chk("pass", pass0, cnt == 0);
        chk("err_count", err0, (cnt > 255) ? 255 : cnt);
        chk("pass_cw2", pass1, cnt == 0);
        chk("err_count_cw2", err1, (cnt > 3) ? 3 : cnt);
        if (cnt > 0) begin
            chk("first_err", ferr0, ferr);
            chk("first_err_cw2", ferr1, ferr);
        end
        chk("vec_addr_done", vec_addr0, n);
        chk("busy_done", busy0, 0);
        if (n > 0) mdin = {tin[n-1], tload[n-1]};
        chk("dut_in_done", dut_in0, mdin);
        mbit = b;
    endtask

    task automatic bit_table(input logic flip2);
        n = 4;
        set_vec(0, 1, 1, 1);
        set_vec(1, 0, 0, 1);
        set_vec(2, 0, 1, flip2);
        set_vec(3, 1, 0, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_vec_addr", vec_addr0, 0);
        chk("rst_dut_in", dut_in0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_err", err0, 0);
        chk("rst_ferr", ferr0, 0);
        reset = 1'b0;
        @(negedge clk);

        // empty table first, so dut_in must remain at its reset value
        n = 0;           run(-1, -1);
        bit_table(1'b0); run(-1, 10);   // reset during SETTLE of vector 2
        bit_table(1'b0); run(-1, -1);
        bit_table(1'b1); run(-1, -1);
        bit_table(1'b0); run(7, -1);    // stray start during CHECK of vector 1
        run(-1, -1);                    // restart from DONE, same table
        n = 5;
        for (int i = 0; i < 5; i++) set_vec(i, 1, 1, 0);
        run(-1, -1);

        for (int t = 0; t < 25; t++) begin
            logic b;
            b = mbit;
            n = $urandom_range(0, 10);
            for (int i = 0; i < n; i++) begin
                tin[i] = 1'($urandom); tload[i] = 1'($urandom);
                if (tload[i]) b = tin[i];
                texp[i] = ($urandom_range(0, 3) == 0) ? 1'($urandom) : b;
            end
            run(-1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
